// File: rtl/codif_morse_pkg.sv
// Shared character codes and the ITU Morse lookup table for codif_morse.
// Table entries are {length[2:0], pattern[4:0]}, pattern left-aligned, 1 = dash.
package codif_morse_pkg;

  localparam int unsigned NUM_CODES = 36;

  localparam logic [5:0] DIGIT_0 = 6'd0;
  localparam logic [5:0] DIGIT_1 = 6'd1;
  localparam logic [5:0] DIGIT_2 = 6'd2;
  localparam logic [5:0] DIGIT_3 = 6'd3;
  localparam logic [5:0] DIGIT_4 = 6'd4;
  localparam logic [5:0] DIGIT_5 = 6'd5;
  localparam logic [5:0] DIGIT_6 = 6'd6;
  localparam logic [5:0] DIGIT_7 = 6'd7;
  localparam logic [5:0] DIGIT_8 = 6'd8;
  localparam logic [5:0] DIGIT_9 = 6'd9;

  localparam logic [5:0] LETTER_A = 6'd10;
  localparam logic [5:0] LETTER_B = 6'd11;
  localparam logic [5:0] LETTER_C = 6'd12;
  localparam logic [5:0] LETTER_D = 6'd13;
  localparam logic [5:0] LETTER_E = 6'd14;
  localparam logic [5:0] LETTER_F = 6'd15;
  localparam logic [5:0] LETTER_G = 6'd16;
  localparam logic [5:0] LETTER_H = 6'd17;
  localparam logic [5:0] LETTER_I = 6'd18;
  localparam logic [5:0] LETTER_J = 6'd19;
  localparam logic [5:0] LETTER_K = 6'd20;
  localparam logic [5:0] LETTER_L = 6'd21;
  localparam logic [5:0] LETTER_M = 6'd22;
  localparam logic [5:0] LETTER_N = 6'd23;
  localparam logic [5:0] LETTER_O = 6'd24;
  localparam logic [5:0] LETTER_P = 6'd25;
  localparam logic [5:0] LETTER_Q = 6'd26;
  localparam logic [5:0] LETTER_R = 6'd27;
  localparam logic [5:0] LETTER_S = 6'd28;
  localparam logic [5:0] LETTER_T = 6'd29;
  localparam logic [5:0] LETTER_U = 6'd30;
  localparam logic [5:0] LETTER_V = 6'd31;
  localparam logic [5:0] LETTER_W = 6'd32;
  localparam logic [5:0] LETTER_X = 6'd33;
  localparam logic [5:0] LETTER_Y = 6'd34;
  localparam logic [5:0] LETTER_Z = 6'd35;

  typedef struct packed {
    logic [4:0] display;
    logic [4:0] morse;
  } morse_code_t;

  localparam logic [7:0] MORSE_TABLE [0:NUM_CODES-1] = '{
    {3'd5, 5'b11111}, {3'd5, 5'b01111}, {3'd5, 5'b00111}, {3'd5, 5'b00011},
    {3'd5, 5'b00001}, {3'd5, 5'b00000}, {3'd5, 5'b10000}, {3'd5, 5'b11000},
    {3'd5, 5'b11100}, {3'd5, 5'b11110},
    {3'd2, 5'b01000}, {3'd4, 5'b10000}, {3'd4, 5'b10100}, {3'd3, 5'b10000},  // A B C D
    {3'd1, 5'b00000}, {3'd4, 5'b00100}, {3'd3, 5'b11000}, {3'd4, 5'b00000},  // E F G H
    {3'd2, 5'b00000}, {3'd4, 5'b01110}, {3'd3, 5'b10100}, {3'd4, 5'b01000},  // I J K L
    {3'd2, 5'b11000}, {3'd2, 5'b10000}, {3'd3, 5'b11100}, {3'd4, 5'b01100},  // M N O P
    {3'd4, 5'b11010}, {3'd3, 5'b01000}, {3'd3, 5'b00000}, {3'd1, 5'b10000},  // Q R S T
    {3'd3, 5'b00100}, {3'd4, 5'b00010}, {3'd3, 5'b01100}, {3'd4, 5'b10010},  // U V W X
    {3'd4, 5'b10110}, {3'd4, 5'b11000}                                        // Y Z
  };

  // Left-aligned valid mask for a code of the given length (0 gives an empty mask).
  function automatic logic [4:0] length_mask(input logic [2:0] len);
    return ~(5'b11111 >> len);
  endfunction

endpackage

// File: rtl/codif_morse_demux.sv
// One lamp position of the downstream LED stage: splits a symbol into dot/dash lamps.
module demux_display (
  input  logic num,
  input  logic display,
  output logic ponto,
  output logic traco
);

  assign ponto = display & ~num;
  assign traco = display & num;

endmodule

// File: rtl/codif_morse.sv
// Encodes a 6-bit character code into registered left-aligned Morse symbols and valid mask.
module codif_morse
  import codif_morse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] num,
  input  logic       ready,
  output logic [4:0] display,
  output logic [4:0] morse
);

  morse_code_t code_next;
  logic [4:0]  display_reg;
  logic [4:0]  morse_reg;
  logic [7:0]  entry;

  always_comb begin
    entry     = '0;
    code_next = '0;
    // Codes 36-63 have no table entry and encode as an empty symbol.
    if (num < 6'(NUM_CODES)) begin
      entry             = MORSE_TABLE[num];
      code_next.display = length_mask(entry[7:5]);
      code_next.morse   = entry[4:0] & code_next.display;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      display_reg <= '0;
      morse_reg   <= '0;
    end else if (ready) begin
      display_reg <= code_next.display;
      morse_reg   <= code_next.morse;
    end
  end

  assign display = display_reg;
  assign morse   = morse_reg;

endmodule

// File: tb/tb_codif_morse.sv
// Directed bench for codif_morse: a dot/dash string model checked every cycle,
// plus hand-computed literal expectations and the downstream lamp demux.
module tb_codif_morse;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] num;
  logic       ready;
  logic [4:0] display;
  logic [4:0] morse;
  logic [4:0] ponto;
  logic [4:0] traco;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  codif_morse dut (
    .clk     (clk),
    .reset   (reset),
    .num     (num),
    .ready   (ready),
    .display (display),
    .morse   (morse)
  );

  for (genvar gi = 0; gi < 5; gi++) begin : g_lamp
    demux_display u_lamp (
      .num     (morse[gi]),
      .display (display[gi]),
      .ponto   (ponto[gi]),
      .traco   (traco[gi])
    );
  end

  string letters [26] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--.."
  };

  // Spells the character as dots and dashes, then lays the symbols out from bit 4 down.
  task automatic model_encode(input int n, output logic [4:0] d, output logic [4:0] m);
    string s;
    s = "";
    if (n < 10) begin
      for (int i = 0; i < 5; i++) begin
        if (n == 0)      s = {s, "-"};
        else if (n <= 5) s = {s, (i < n) ? "." : "-"};
        else             s = {s, (i < n - 5) ? "-" : "."};
      end
    end else if (n < 36) begin
      s = letters[n - 10];
    end
    d = '0;
    m = '0;
    for (int i = 0; i < s.len(); i++) begin
      d[4 - i] = 1'b1;
      m[4 - i] = (s[i] == "-");
    end
  endtask

  logic [4:0] exp_display = '0;
  logic [4:0] exp_morse   = '0;
  logic       model_valid = 1'b0;

  always @(posedge clk) begin
    logic [4:0] d, m;
    if (!reset) begin
      exp_display = '0;
      exp_morse   = '0;
      model_valid = 1'b1;
    end else if (ready) begin
      model_encode(int'(num), d, m);
      exp_display = d;
      exp_morse   = m;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      vectors++;
      if (display !== exp_display || morse !== exp_morse) begin
        miscompares++;
        $display("FAIL model t=%0t num=%0d: got display=%b morse=%b, expected display=%b morse=%b",
                 $time, num, display, morse, exp_display, exp_morse);
      end
    end
  end

  task automatic step(input logic r, input logic rd, input logic [5:0] n);
    reset = r;
    ready = rd;
    num   = n;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [4:0] ed, input logic [4:0] em);
    vectors++;
    if (display !== ed || morse !== em) begin
      miscompares++;
      $display("FAIL %s: got display=%b morse=%b, expected display=%b morse=%b",
               name, display, morse, ed, em);
    end
    $display("vector %s: num=%0d display=%b morse=%b", name, num, display, morse);
  endtask

  task automatic check_lamps(input string name, input logic [4:0] ep, input logic [4:0] et);
    vectors++;
    if (ponto !== ep || traco !== et) begin
      miscompares++;
      $display("FAIL %s: got ponto=%b traco=%b, expected ponto=%b traco=%b",
               name, ponto, traco, ep, et);
    end
    $display("vector %s: ponto=%b traco=%b", name, ponto, traco);
  endtask

  initial begin
    reset = 1'b0;
    ready = 1'b0;
    num   = '0;
    @(negedge clk);
    step(1'b0, 1'b0, 6'd0);   check("reset",   5'b00000, 5'b00000);

    step(1'b1, 1'b1, 6'd1);   check("digit1",  5'b11111, 5'b01111);
    check_lamps("lamps1", 5'b10000, 5'b01111);
    step(1'b1, 1'b1, 6'd0);   check("digit0",  5'b11111, 5'b11111);
    step(1'b1, 1'b1, 6'd9);   check("digit9",  5'b11111, 5'b11110);
    step(1'b1, 1'b1, 6'd10);  check("letterA", 5'b11000, 5'b01000);
    check_lamps("lampsA", 5'b10000, 5'b01000);
    step(1'b1, 1'b1, 6'd14);  check("letterE", 5'b10000, 5'b00000);
    step(1'b1, 1'b1, 6'd29);  check("letterT", 5'b10000, 5'b10000);
    step(1'b1, 1'b1, 6'd26);  check("letterQ", 5'b11110, 5'b11010);
    step(1'b1, 1'b1, 6'd35);  check("letterZ", 5'b11110, 5'b11000);

    step(1'b1, 1'b1, 6'd11);  check("letterB", 5'b11110, 5'b10000);
    step(1'b1, 1'b0, 6'd22);  check("hold1",   5'b11110, 5'b10000);
    step(1'b1, 1'b0, 6'd5);   check("hold2",   5'b11110, 5'b10000);
    step(1'b1, 1'b1, 6'd40);  check("invalid", 5'b00000, 5'b00000);

    step(1'b1, 1'b1, 6'd7);   check("digit7",  5'b11111, 5'b11000);
    step(1'b0, 1'b1, 6'd3);   check("rst_pri", 5'b00000, 5'b00000);
    step(1'b1, 1'b0, 6'd3);   check("post_rst",5'b00000, 5'b00000);
    step(1'b1, 1'b1, 6'd3);   check("digit3",  5'b11111, 5'b00011);
    step(1'b1, 1'b1, 6'd63);  check("code63",  5'b00000, 5'b00000);

    // Every code back to back; the model process checks each cycle.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 6'(i));
    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0), 6'($urandom_range(0, 63)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
